// File: rtl/fetch_address_generator.sv
// Fetch address generator: walks the PC through fetch requests, holds fetched
// instructions for decode, and applies branch/jump redirects from execute.
module fetch_address_generator #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        redirect_valid,
  input  logic        redirect_is_jump,
  input  logic [31:0] redirect_address,
  output logic        fetch_enable,
  output logic [31:0] fetch_address,
  output logic        fetch_branch_enable,
  output logic        fetch_jump_enable,
  input  logic [31:0] fetch_instruction,
  input  logic        fetch_done,
  output logic [31:0] decode_instruction,
  output logic [31:0] decode_pc,
  output logic        decode_valid,
  input  logic        decode_ready
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            fetch_enable_n;
  logic [XLEN-1:0] fetch_address_n;
  logic            fetch_branch_enable_n;
  logic            fetch_jump_enable_n;
  logic [XLEN-1:0] decode_instruction_n;
  logic [XLEN-1:0] decode_pc_n;
  logic            decode_valid_n;

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output logic; a redirect overrides everything else
  always_comb begin
    state_n               = state;
    pc_n                  = pc;
    fetch_enable_n        = fetch_enable;
    fetch_address_n       = fetch_address;
    fetch_branch_enable_n = 1'b0;
    fetch_jump_enable_n   = 1'b0;
    decode_instruction_n  = decode_instruction;
    decode_pc_n           = decode_pc;
    decode_valid_n        = decode_valid;

    if (redirect_valid) begin
      pc_n                  = {redirect_address[XLEN-1:2], 2'b00};
      fetch_address_n       = {redirect_address[XLEN-1:2], 2'b00};
      fetch_enable_n        = 1'b1;
      fetch_branch_enable_n = ~redirect_is_jump;
      fetch_jump_enable_n   = redirect_is_jump;
      decode_valid_n        = 1'b0;
      state_n               = REQUEST;
    end else begin
      case (state)
        IDLE: begin
          fetch_enable_n  = 1'b1;
          fetch_address_n = pc;
          state_n         = REQUEST;
        end
        REQUEST: begin
          if (fetch_done) begin
            decode_instruction_n = fetch_instruction;
            decode_pc_n          = pc;
            decode_valid_n       = 1'b1;
            pc_n                 = pc + XLEN'(PC_STEP);
            fetch_enable_n       = 1'b0;
            state_n              = HOLD;
          end
        end
        HOLD: begin
          if (decode_ready) begin
            decode_valid_n  = 1'b0;
            fetch_enable_n  = 1'b1;
            fetch_address_n = pc;
            state_n         = REQUEST;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // PC and registered outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc                  <= RESET_ADDRESS;
      fetch_enable        <= 1'b0;
      fetch_address       <= RESET_ADDRESS;
      fetch_branch_enable <= 1'b0;
      fetch_jump_enable   <= 1'b0;
      decode_instruction  <= '0;
      decode_pc           <= '0;
      decode_valid        <= 1'b0;
    end else begin
      pc                  <= pc_n;
      fetch_enable        <= fetch_enable_n;
      fetch_address       <= fetch_address_n;
      fetch_branch_enable <= fetch_branch_enable_n;
      fetch_jump_enable   <= fetch_jump_enable_n;
      decode_instruction  <= decode_instruction_n;
      decode_pc           <= decode_pc_n;
      decode_valid        <= decode_valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_address_generator.sv
// Directed bench for fetch_address_generator: vector table plus reset sequences.
module tb_fetch_address_generator;

  logic        CLK;
  logic        Reset;
  logic        redirect_valid;
  logic        redirect_is_jump;
  logic [31:0] redirect_address;
  logic        fetch_enable;
  logic [31:0] fetch_address;
  logic        fetch_branch_enable;
  logic        fetch_jump_enable;
  logic [31:0] fetch_instruction;
  logic        fetch_done;
  logic [31:0] decode_instruction;
  logic [31:0] decode_pc;
  logic        decode_valid;
  logic        decode_ready;

  int checks;
  int failures;

  fetch_address_generator #(.RESET_ADDRESS(32'h0000_0000)) dut (
    .CLK                 (CLK),
    .Reset               (Reset),
    .redirect_valid      (redirect_valid),
    .redirect_is_jump    (redirect_is_jump),
    .redirect_address    (redirect_address),
    .fetch_enable        (fetch_enable),
    .fetch_address       (fetch_address),
    .fetch_branch_enable (fetch_branch_enable),
    .fetch_jump_enable   (fetch_jump_enable),
    .fetch_instruction   (fetch_instruction),
    .fetch_done          (fetch_done),
    .decode_instruction  (decode_instruction),
    .decode_pc           (decode_pc),
    .decode_valid        (decode_valid),
    .decode_ready        (decode_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rv;
    logic        rj;
    logic [31:0] ra;
    logic [31:0] fi;
    logic        fd;
    logic        dr;
    logic        fe;
    logic [31:0] fa;
    logic        fbe;
    logic        fje;
    logic [31:0] di;
    logic [31:0] dpc;
    logic        dv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic rj, input logic [31:0] ra,
                     input logic [31:0] fi, input logic fd, input logic dr,
                     input logic fe, input logic [31:0] fa, input logic fbe,
                     input logic fje, input logic [31:0] di, input logic [31:0] dpc,
                     input logic dv);
    vec_t v;
    v.rv = rv; v.rj = rj; v.ra = ra; v.fi = fi; v.fd = fd; v.dr = dr;
    v.fe = fe; v.fa = fa; v.fbe = fbe; v.fje = fje; v.di = di; v.dpc = dpc; v.dv = dv;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rv, input logic rj, input logic [31:0] ra,
                       input logic [31:0] fi, input logic fd, input logic dr);
    redirect_valid    = rv;
    redirect_is_jump  = rj;
    redirect_address  = ra;
    fetch_instruction = fi;
    fetch_done        = fd;
    decode_ready      = dr;
  endtask

  task automatic check(input string name, input logic fe, input logic [31:0] fa,
                       input logic fbe, input logic fje, input logic [31:0] di,
                       input logic [31:0] dpc, input logic dv);
    checks++;
    if (fetch_enable !== fe || fetch_address !== fa || fetch_branch_enable !== fbe ||
        fetch_jump_enable !== fje || decode_instruction !== di || decode_pc !== dpc ||
        decode_valid !== dv) begin
      failures++;
      $display("FAIL %s: got fe=%b fa=%h fbe=%b fje=%b di=%h dpc=%h dv=%b, expected fe=%b fa=%h fbe=%b fje=%b di=%h dpc=%h dv=%b",
               name, fetch_enable, fetch_address, fetch_branch_enable, fetch_jump_enable,
               decode_instruction, decode_pc, decode_valid, fe, fa, fbe, fje, di, dpc, dv);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // rv rj ra fi fd dr | fe fa fbe fje di dpc dv
    add(0,0,32'h0,32'h0,0,0,        1,32'h0,0,0,32'h0,32'h0,0);           // IDLE -> REQUEST
    add(0,0,32'h0,32'h11,1,0,       0,32'h0,0,0,32'h11,32'h0,1);          // fetch @0
    add(0,0,32'h0,32'h0,0,1,        1,32'h4,0,0,32'h11,32'h0,0);          // request @4
    add(0,0,32'h0,32'h22,1,1,       0,32'h4,0,0,32'h22,32'h4,1);          // fetch @4
    add(0,0,32'h0,32'h0,0,1,        1,32'h8,0,0,32'h22,32'h4,0);
    add(0,0,32'h0,32'h33,1,1,       0,32'h8,0,0,32'h33,32'h8,1);          // fetch @8
    for (int i = 0; i < 5; i++)                                           // backpressure
      add(0,0,32'h0,32'hDEAD,1,0,   0,32'h8,0,0,32'h33,32'h8,1);
    add(0,0,32'h0,32'h0,0,1,        1,32'hC,0,0,32'h33,32'h8,0);          // release -> pc+4
    add(1,0,32'h103,32'h44,1,1,     1,32'h100,1,0,32'h33,32'h8,0);        // branch vs fetch_done
    add(0,0,32'h0,32'h0,0,0,        1,32'h100,0,0,32'h33,32'h8,0);
    add(0,0,32'h0,32'h55,1,0,       0,32'h100,0,0,32'h55,32'h100,1);
    add(1,1,32'h40,32'h0,0,0,       1,32'h40,0,1,32'h55,32'h100,0);       // jump in HOLD
    add(0,0,32'h0,32'h0,0,0,        1,32'h40,0,0,32'h55,32'h100,0);
    add(1,0,32'h200,32'h0,0,0,      1,32'h200,1,0,32'h55,32'h100,0);      // back-to-back
    add(1,1,32'h300,32'h0,0,0,      1,32'h300,0,1,32'h55,32'h100,0);
    add(0,0,32'h0,32'h0,0,0,        1,32'h300,0,0,32'h55,32'h100,0);
    add(1,1,32'hFFFF_FFFF,32'h0,0,0,1,32'hFFFF_FFFC,0,1,32'h55,32'h100,0);// wrap target
    add(0,0,32'h0,32'h66,1,0,       0,32'hFFFF_FFFC,0,0,32'h66,32'hFFFF_FFFC,1);
    add(0,0,32'h0,32'h0,0,1,        1,32'h0,0,0,32'h66,32'hFFFF_FFFC,0);

    // Reset state, before and across a clock edge
    #1;
    check("reset_async", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h77, 1'b1, 1'b1);
    step();
    check("reset_held", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].rj, vecs[i].ra, vecs[i].fi, vecs[i].fd, vecs[i].dr);
      step();
      check($sformatf("vec%0d", i), vecs[i].fe, vecs[i].fa, vecs[i].fbe, vecs[i].fje,
            vecs[i].di, vecs[i].dpc, vecs[i].dv);
    end

    // Async reset between edges during REQUEST
    drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
    step();
    check("pre_reset_req", 1, 32'h80, 1, 0, 32'h66, 32'hFFFF_FFFC, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("reset_mid_request", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    #2;
    Reset = 1'b0;
    step();
    check("first_req_after_reset", 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // Async reset during HOLD abandons the held instruction
    drive(1'b0, 1'b0, 32'h0, 32'h99, 1'b1, 1'b0);
    step();
    check("hold_before_reset", 0, 32'h0, 0, 0, 32'h99, 32'h0, 1);
    #2;
    Reset = 1'b1;
    #1;
    check("reset_mid_hold", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #2;
    Reset = 1'b0;
    step();
    check("after_hold_reset", 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    step();
    check("no_stale_valid", 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
